// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle main controller and the datapath/memory.
// The master (controller) consumes decode fields and status and drives every datapath enable.
interface multicycle_control_if #(
   parameter int unsigned OP_W = 6,
   parameter int unsigned FN_W = 6
);
   logic [OP_W-1:0] opcode;
   logic [FN_W-1:0] funct;
   logic            zero;
   logic            mem_ready;
   logic            pc_en;
   logic [1:0]      pc_source;
   logic            i_or_d;
   logic            mem_read;
   logic            mem_write;
   logic            ir_write;
   logic            reg_dst;
   logic            mem_to_reg;
   logic            reg_write;
   logic            alu_src_a;
   logic [1:0]      alu_src_b;
   logic [3:0]      alu_operation;
   logic            illegal;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_operation, illegal
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
             reg_write, alu_src_a, alu_src_b, alu_operation, illegal
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset main control FSM: fetch/decode/execute/memory/writeback sequencing
// with Moore state-decoded outputs; pc_en and ir_write also depend on zero/mem_ready.
module multicycle_control #(
   parameter int unsigned OP_W = 6,
   parameter int unsigned FN_W = 6
) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.master ctrl_io
);
   localparam logic [OP_W-1:0] OpR    = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OpJ    = OP_W'(6'b000010);
   localparam logic [OP_W-1:0] OpBeq  = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OpBne  = OP_W'(6'b000101);
   localparam logic [OP_W-1:0] OpAddi = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OpSlti = OP_W'(6'b001010);
   localparam logic [OP_W-1:0] OpAndi = OP_W'(6'b001100);
   localparam logic [OP_W-1:0] OpOri  = OP_W'(6'b001101);
   localparam logic [OP_W-1:0] OpLw   = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OpSw   = OP_W'(6'b101011);

   localparam logic [FN_W-1:0] FnAdd = FN_W'(6'b100000);
   localparam logic [FN_W-1:0] FnSub = FN_W'(6'b100010);
   localparam logic [FN_W-1:0] FnAnd = FN_W'(6'b100100);
   localparam logic [FN_W-1:0] FnOr  = FN_W'(6'b100101);
   localparam logic [FN_W-1:0] FnSlt = FN_W'(6'b101010);

   localparam logic [3:0] AluAnd = 4'b0000;
   localparam logic [3:0] AluOr  = 4'b0001;
   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluSub = 4'b0011;
   localparam logic [3:0] AluNe  = 4'b0110;
   localparam logic [3:0] AluSlt = 4'b0111;

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAddr, StMemRead, StMemWb, StMemWrite, StRExec, StRWb,
      StIExec, StIWb, StBranch, StJump, StIllegal
   } state_e;

   state_e state_q, state_d;
   logic   is_store_q, is_store_d;
   logic   illegal_q, illegal_d;

   logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a;
   logic [1:0] pc_source, alu_src_b;
   logic [3:0] alu_operation;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StFetch;
         is_store_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         illegal_q  <= illegal_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      is_store_d    = is_store_q;
      pc_en         = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_operation = AluAnd;
      unique case (state_q)
         StFetch: begin
            mem_read      = 1'b1;
            alu_src_b     = 2'b01;
            alu_operation = AluAdd;
            ir_write      = ctrl_io.mem_ready;
            pc_en         = ctrl_io.mem_ready;
            if (ctrl_io.mem_ready) state_d = StDecode;
         end
         StDecode: begin
            alu_src_b     = 2'b11;
            alu_operation = AluAdd;
            // lw/sw choice is latched here so MEM_ADDR never looks at the opcode.
            is_store_d    = (ctrl_io.opcode == OpSw);
            if (ctrl_io.opcode == OpLw || ctrl_io.opcode == OpSw) state_d = StMemAddr;
            else if (ctrl_io.opcode == OpR) state_d = StRExec;
            else if (ctrl_io.opcode == OpBeq || ctrl_io.opcode == OpBne) state_d = StBranch;
            else if (ctrl_io.opcode == OpJ) state_d = StJump;
            else if (ctrl_io.opcode == OpAddi || ctrl_io.opcode == OpAndi ||
                     ctrl_io.opcode == OpOri || ctrl_io.opcode == OpSlti) state_d = StIExec;
            else state_d = StIllegal;
         end
         StMemAddr: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'b10;
            alu_operation = AluAdd;
            state_d       = is_store_q ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (ctrl_io.mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = StFetch;
         end
         StMemWrite: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (ctrl_io.mem_ready) state_d = StFetch;
         end
         StRExec: begin
            alu_src_a = 1'b1;
            state_d   = StRWb;
            case (ctrl_io.funct)
               FnAdd:   alu_operation = AluAdd;
               FnSub:   alu_operation = AluSub;
               FnAnd:   alu_operation = AluAnd;
               FnOr:    alu_operation = AluOr;
               FnSlt:   alu_operation = AluSlt;
               default: state_d = StIllegal;
            endcase
         end
         StRWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = StFetch;
         end
         StIExec: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = StIWb;
            case (ctrl_io.opcode)
               OpAndi:  alu_operation = AluAnd;
               OpOri:   alu_operation = AluOr;
               OpSlti:  alu_operation = AluSlt;
               default: alu_operation = AluAdd;
            endcase
         end
         StIWb: begin
            reg_write = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            pc_source = 2'b01;
            state_d   = StFetch;
            if (ctrl_io.opcode == OpBne) begin
               alu_operation = AluNe;
               pc_en         = ~ctrl_io.zero;
            end else begin
               alu_operation = AluSub;
               pc_en         = ctrl_io.zero;
            end
         end
         StJump: begin
            pc_source = 2'b10;
            pc_en     = 1'b1;
            state_d   = StFetch;
         end
         StIllegal: state_d = StIllegal;
         default:   state_d = StFetch;
      endcase
      illegal_d = illegal_q | (state_d == StIllegal);
   end

   // Reset abandons any access at once: no PC or IR load while rst_n is low.
   assign ctrl_io.pc_en         = pc_en & rst_n;
   assign ctrl_io.ir_write      = ir_write & rst_n;
   assign ctrl_io.pc_source     = pc_source;
   assign ctrl_io.i_or_d        = i_or_d;
   assign ctrl_io.mem_read      = mem_read;
   assign ctrl_io.mem_write     = mem_write;
   assign ctrl_io.reg_dst       = reg_dst;
   assign ctrl_io.mem_to_reg    = mem_to_reg;
   assign ctrl_io.reg_write     = reg_write;
   assign ctrl_io.alu_src_a     = alu_src_a;
   assign ctrl_io.alu_src_b     = alu_src_b;
   assign ctrl_io.alu_operation = alu_operation;
   assign ctrl_io.illegal       = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output scripts built from the
// instruction's meaning, random wait/zero/junk stimulus, plus hand-written literal checks.
module tb_multicycle_control;
   typedef struct packed {
      logic       pc_en;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_operation;
      logic       illegal;
   } ctrl_t;

   localparam logic [5:0] OpR = 6'b000000, OpJ = 6'b000010, OpBeq = 6'b000100;
   localparam logic [5:0] OpBne = 6'b000101, OpAddi = 6'b001000, OpSlti = 6'b001010;
   localparam logic [5:0] OpAndi = 6'b001100, OpOri = 6'b001101, OpLw = 6'b100011;
   localparam logic [5:0] OpSw = 6'b101011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_control_if #(.OP_W(6), .FN_W(6)) bus ();
   multicycle_control #(.OP_W(6), .FN_W(6)) dut (.clk(clk), .rst_n(rst_n), .ctrl_io(bus));

   int    n_checks = 0;
   int    n_errors = 0;
   ctrl_t exp_v;
   bit    exp_valid = 1'b0;
   string exp_name = "";

   logic [5:0] legal_ops [10] = '{OpR, OpJ, OpBeq, OpBne, OpAddi, OpSlti, OpAndi, OpOri,
                                  OpLw, OpSw};
   logic [5:0] legal_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
      end
   endtask

   function automatic ctrl_t actual();
      ctrl_t a;
      a.pc_en = bus.pc_en;           a.pc_source = bus.pc_source;
      a.i_or_d = bus.i_or_d;         a.mem_read = bus.mem_read;
      a.mem_write = bus.mem_write;   a.ir_write = bus.ir_write;
      a.reg_dst = bus.reg_dst;       a.mem_to_reg = bus.mem_to_reg;
      a.reg_write = bus.reg_write;   a.alu_src_a = bus.alu_src_a;
      a.alu_src_b = bus.alu_src_b;   a.alu_operation = bus.alu_operation;
      a.illegal = bus.illegal;
      return a;
   endfunction

   always @(negedge clk) begin
      if (exp_valid) check(exp_name, 32'(actual()), 32'(exp_v));
   end

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [5:0] rnd6();
      return 6'($urandom);
   endfunction

   // {legal, alu code}
   function automatic logic [4:0] r_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 5'b1_0010;
         6'b100010: return 5'b1_0011;
         6'b100100: return 5'b1_0000;
         6'b100101: return 5'b1_0001;
         6'b101010: return 5'b1_0111;
         default:   return 5'b0_0000;
      endcase
   endfunction

   function automatic logic [4:0] i_alu(input logic [5:0] op);
      case (op)
         OpAddi:  return 5'b1_0010;
         OpAndi:  return 5'b1_0000;
         OpOri:   return 5'b1_0001;
         OpSlti:  return 5'b1_0111;
         default: return 5'b0_0000;
      endcase
   endfunction

   function automatic ctrl_t fetch_v(input logic done);
      ctrl_t e = '0;
      e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_operation = 4'b0010;
      e.ir_write = done; e.pc_en = done;
      return e;
   endfunction

   function automatic ctrl_t decode_v();
      ctrl_t e = '0;
      e.alu_src_b = 2'b11; e.alu_operation = 4'b0010;
      return e;
   endfunction

   function automatic ctrl_t mem_addr_v();
      ctrl_t e = '0;
      e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_operation = 4'b0010;
      return e;
   endfunction

   task automatic cyc(input string name, input ctrl_t e, input logic [5:0] o,
                      input logic [5:0] f, input logic z, input logic r);
      bus.opcode = o; bus.funct = f; bus.zero = z; bus.mem_ready = r;
      exp_v = e; exp_name = name; exp_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One instruction from FETCH back to FETCH; ill reports that it ended in the illegal state.
   task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int fw,
                            input int mw, input logic zr, output bit ill);
      ctrl_t e;
      logic [4:0] op;
      ill = 1'b0;
      for (int i = 0; i < fw; i++) cyc("fetch_wait", fetch_v(1'b0), rnd6(), rnd6(), rb(), 1'b0);
      cyc("fetch", fetch_v(1'b1), rnd6(), rnd6(), rb(), 1'b1);
      cyc("decode", decode_v(), opc, fn, rb(), rb());
      if (opc == OpLw || opc == OpSw) begin
         cyc("mem_addr", mem_addr_v(), rnd6(), rnd6(), rb(), rb());
         e = '0; e.i_or_d = 1'b1;
         if (opc == OpLw) e.mem_read = 1'b1;
         else e.mem_write = 1'b1;
         for (int i = 0; i < mw; i++) cyc("mem_wait", e, rnd6(), rnd6(), rb(), 1'b0);
         cyc("mem_done", e, rnd6(), rnd6(), rb(), 1'b1);
         if (opc == OpLw) begin
            e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            cyc("mem_wb", e, rnd6(), rnd6(), rb(), rb());
         end
      end else if (opc == OpR) begin
         op = r_alu(fn);
         e = '0; e.alu_src_a = 1'b1; e.alu_operation = op[3:0];
         cyc("r_exec", e, rnd6(), fn, rb(), rb());
         if (op[4]) begin
            e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
            cyc("r_wb", e, rnd6(), rnd6(), rb(), rb());
         end else ill = 1'b1;
      end else if (opc == OpBeq || opc == OpBne) begin
         e = '0; e.alu_src_a = 1'b1; e.pc_source = 2'b01;
         e.alu_operation = (opc == OpBne) ? 4'b0110 : 4'b0011;
         e.pc_en = (opc == OpBne) ? !zr : zr;
         cyc("branch", e, opc, rnd6(), zr, rb());
      end else if (opc == OpJ) begin
         e = '0; e.pc_source = 2'b10; e.pc_en = 1'b1;
         cyc("jump", e, rnd6(), rnd6(), rb(), rb());
      end else if (i_alu(opc) != 5'b0) begin
         op = i_alu(opc);
         e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_operation = op[3:0];
         cyc("i_exec", e, opc, rnd6(), rb(), rb());
         e = '0; e.reg_write = 1'b1;
         cyc("i_wb", e, rnd6(), rnd6(), rb(), rb());
      end else ill = 1'b1;
   endtask

   task automatic pulse_reset();
      exp_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_illegal", 32'(bus.illegal), 32'd0);
      check("reset_mem_read", 32'(bus.mem_read), 32'd1);
      check("reset_pc_en", 32'(bus.pc_en), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic hold_illegal_then_reset();
      ctrl_t e = '0;
      e.illegal = 1'b1;
      for (int i = 0; i < 12; i++) cyc("illegal_hold", e, rnd6(), rnd6(), rb(), rb());
      pulse_reset();
   endtask

   task automatic reset_during_store();
      ctrl_t e = '0;
      cyc("fetch", fetch_v(1'b1), rnd6(), rnd6(), rb(), 1'b1);
      cyc("decode", decode_v(), OpSw, rnd6(), rb(), rb());
      cyc("mem_addr", mem_addr_v(), rnd6(), rnd6(), rb(), rb());
      e.mem_write = 1'b1; e.i_or_d = 1'b1;
      cyc("mem_wait", e, rnd6(), rnd6(), rb(), 1'b0);
      exp_valid = 1'b0;
      bus.mem_ready = 1'b0;
      #1 check("sw_mem_write_before_reset", 32'(bus.mem_write), 32'd1);
      bus.mem_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check("sw_reset_mem_write", 32'(bus.mem_write), 32'd0);
      check("sw_reset_mem_read", 32'(bus.mem_read), 32'd1);
      check("sw_reset_i_or_d", 32'(bus.i_or_d), 32'd0);
      check("sw_reset_pc_en", 32'(bus.pc_en), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ill;
      logic [5:0] opc, fn;
      bus.opcode = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      #3;
      check("rst_mem_read", 32'(bus.mem_read), 32'd1);
      check("rst_alu_src_b", 32'(bus.alu_src_b), 32'd1);
      check("rst_alu_op", 32'(bus.alu_operation), 32'b0010);
      check("rst_pc_en", 32'(bus.pc_en), 32'd0);
      check("rst_illegal", 32'(bus.illegal), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Hand-computed sub sequence: FETCH, DECODE, R_EXEC, R_WB, FETCH.
      bus.opcode = OpR; bus.funct = 6'b100010; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      check("lit_fetch_pc_en", 32'(bus.pc_en), 32'd1);
      check("lit_fetch_ir_write", 32'(bus.ir_write), 32'd1);
      @(negedge clk);
      check("lit_decode_src_b", 32'(bus.alu_src_b), 32'b11);
      check("lit_decode_pc_en", 32'(bus.pc_en), 32'd0);
      @(negedge clk);
      check("lit_rexec_op", 32'(bus.alu_operation), 32'b0011);
      check("lit_rexec_src_b", 32'(bus.alu_src_b), 32'b00);
      check("lit_rexec_src_a", 32'(bus.alu_src_a), 32'd1);
      @(negedge clk);
      check("lit_rwb_reg_write", 32'(bus.reg_write), 32'd1);
      check("lit_rwb_reg_dst", 32'(bus.reg_dst), 32'd1);
      @(negedge clk);
      check("lit_fetch2_mem_read", 32'(bus.mem_read), 32'd1);
      check("lit_fetch2_pc_en", 32'(bus.pc_en), 32'd1);
      bus.mem_ready = 1'b0;
      #1 check("lit_fetch2_pc_en_wait", 32'(bus.pc_en), 32'd0);
      @(posedge clk);
      #1;

      // Hand-computed bne, zero=0 then zero=1 in the same BRANCH cycle.
      bus.opcode = OpBne; bus.funct = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("lit_bne_pc_en", 32'(bus.pc_en), 32'd1);
      check("lit_bne_op", 32'(bus.alu_operation), 32'b0110);
      check("lit_bne_pc_source", 32'(bus.pc_source), 32'b01);
      bus.zero = 1'b1;
      #1 check("lit_bne_equal_pc_en", 32'(bus.pc_en), 32'd0);
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;

      run_instr(OpLw, rnd6(), 0, 3, 1'b0, ill);
      run_instr(OpBeq, rnd6(), 0, 0, 1'b1, ill);
      run_instr(OpBeq, rnd6(), 0, 0, 1'b0, ill);
      run_instr(OpBne, rnd6(), 0, 0, 1'b0, ill);
      run_instr(OpR, 6'b100000, 5, 0, 1'b0, ill);
      run_instr(OpSw, rnd6(), 1, 2, 1'b0, ill);
      run_instr(OpJ, rnd6(), 0, 0, 1'b0, ill);
      run_instr(OpAddi, rnd6(), 0, 0, 1'b0, ill);
      run_instr(OpAndi, rnd6(), 0, 0, 1'b0, ill);
      run_instr(OpOri, rnd6(), 0, 0, 1'b0, ill);
      run_instr(OpSlti, rnd6(), 0, 0, 1'b0, ill);
      reset_during_store();

      for (int n = 0; n < 150; n++) begin
         opc = legal_ops[$urandom_range(0, 9)];
         fn = legal_fns[$urandom_range(0, 4)];
         if ($urandom_range(0, 9) == 0) begin
            opc = rnd6();
            fn = rnd6();
         end
         run_instr(opc, fn, $urandom_range(0, 3), $urandom_range(0, 3), rb(), ill);
         if (ill) hold_illegal_then_reset();
      end

      run_instr(6'b111111, rnd6(), 0, 0, 1'b0, ill);
      check("illegal_opcode_flagged", 32'(ill), 32'd1);
      if (ill) hold_illegal_then_reset();
      run_instr(OpR, 6'b000111, 0, 0, 1'b0, ill);
      check("illegal_funct_flagged", 32'(ill), 32'd1);
      if (ill) hold_illegal_then_reset();
      run_instr(OpLw, rnd6(), 2, 1, 1'b0, ill);
      exp_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
